// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite controller: command encodings, FSM
// states, the reset value of the scale register and a sign-extension helper.
package sprite_pkg;

    typedef enum logic [1:0] {
        CMD_PIXEL = 2'd0,
        CMD_POS   = 2'd1,
        CMD_SCALE = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    // Unity scale for the sprite.
    localparam logic [31:0] SCALE_RESET = 32'd8;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/sprite_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - requester with highest priority this cycle
//   grant - one-hot winner (all zero when no request)
//   idx   - encoded winner index
//   valid - at least one request present
// The winner is the first set bit at or above ptr, wrapping past the top.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        logic [IDX_W-1:0] cand;
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_ctrl.sv
// Sprite controller: shares one sprite among NUM_REQ requesters.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   req_valid/cmd/addr/data - per-requester command, held until req_ack
//   req_ack         - one-cycle completion pulse to the granted requester
//   frame_start     - vblank pulse; commits pending position/scale
//   bitmap_address/din/we - sprite bitmap write port
//   x, y, scale     - committed sprite position and scale
//   busy            - a command is in progress
// Position and scale land in shadow registers and only reach x/y/scale on
// frame_start, so a sprite never moves in the middle of a frame.
module sprite_ctrl
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BPP       = 8,
    parameter int ADDR_BITS = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*2-1:0]  req_cmd,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    input  logic                  frame_start,
    output logic [31:0]           bitmap_address,
    output logic [BPP-1:0]        bitmap_din,
    output logic                  bitmap_we,
    output logic signed [31:0]    x,
    output logic signed [31:0]    y,
    output logic [31:0]           scale,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state, next_state;
    logic [IDX_W-1:0]     rr_ptr, win_idx;
    logic [NUM_REQ-1:0]   win_onehot, grant_q;
    logic                 win_valid;
    cmd_e                 win_cmd, cmd_q;
    logic [31:0]          win_addr, win_data, data_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [BPP-1:0]       din_q;
    logic signed [31:0]   x_sh, y_sh;
    logic [31:0]          scale_sh;
    logic                 commit_pending;
    logic                 clear_last;
    logic                 unused_addr_hi;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (win_onehot),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign win_cmd        = cmd_e'(req_cmd[2*win_idx +: 2]);
    assign win_addr       = req_addr[32*win_idx +: 32];
    assign win_data       = req_data[32*win_idx +: 32];
    assign unused_addr_hi = ^win_addr[31:ADDR_BITS];

    // During CLEAR the address register doubles as the sweep counter.
    assign clear_last = (state == S_CLEAR) && (addr_q == '1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (win_valid)
                         next_state = (win_cmd == CMD_CLEAR) ? S_CLEAR : S_ISSUE;
            S_ISSUE: next_state = S_IDLE;
            S_CLEAR: if (clear_last) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase

        bitmap_we = ((state == S_ISSUE) && (cmd_q == CMD_PIXEL)) || (state == S_CLEAR);
        req_ack   = ((state == S_ISSUE) || clear_last) ? grant_q : '0;
        busy      = (state != S_IDLE);
    end

    // Address/data registers only change at a grant or during the sweep, so
    // they naturally hold their last written value while bitmap_we is low.
    assign bitmap_address = 32'(addr_q);
    assign bitmap_din     = din_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr         <= '0;
            grant_q        <= '0;
            cmd_q          <= CMD_PIXEL;
            data_q         <= '0;
            addr_q         <= '0;
            din_q          <= '0;
            x_sh           <= '0;
            y_sh           <= '0;
            scale_sh       <= SCALE_RESET;
            x              <= '0;
            y              <= '0;
            scale          <= SCALE_RESET;
            commit_pending <= 1'b0;
        end else begin
            if (state == S_IDLE && win_valid) begin
                grant_q <= win_onehot;
                cmd_q   <= win_cmd;
                data_q  <= win_data;
                rr_ptr  <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                if (win_cmd == CMD_PIXEL) begin
                    addr_q <= win_addr[ADDR_BITS-1:0];
                    din_q  <= win_data[BPP-1:0];
                end else if (win_cmd == CMD_CLEAR) begin
                    addr_q <= '0;
                    din_q  <= win_data[BPP-1:0];
                end
            end

            if (state == S_CLEAR && !clear_last)
                addr_q <= addr_q + 1'b1;

            // Commit reads the pre-edge shadow; a POS/SCALE issuing in the same
            // cycle re-arms commit_pending so its value lands next frame.
            if (frame_start && commit_pending) begin
                x              <= x_sh;
                y              <= y_sh;
                scale          <= scale_sh;
                commit_pending <= 1'b0;
            end

            if (state == S_ISSUE) begin
                if (cmd_q == CMD_POS) begin
                    x_sh           <= sext16(data_q[15:0]);
                    y_sh           <= sext16(data_q[31:16]);
                    commit_pending <= 1'b1;
                end else if (cmd_q == CMD_SCALE) begin
                    scale_sh       <= {28'd0, data_q[3:0]};
                    commit_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_ctrl.sv
// Self-checking bench for sprite_ctrl (NUM_REQ=4, BPP=8, ADDR_BITS=4).
// A transaction-level reference model predicts every output each cycle;
// directed scenarios add explicit expectations on top of it.
module tb_sprite_ctrl;
    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [2*N-1:0]  req_cmd;
    logic [32*N-1:0] req_addr, req_data;
    logic          frame_start;
    logic [N-1:0]  req_ack;
    logic [31:0]   bitmap_address;
    logic [7:0]    bitmap_din;
    logic          bitmap_we;
    logic signed [31:0] x, y;
    logic [31:0]   scale;
    logic          busy;

    sprite_ctrl #(.NUM_REQ(N), .BPP(8), .ADDR_BITS(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_ack(req_ack),
        .frame_start(frame_start), .bitmap_address(bitmap_address),
        .bitmap_din(bitmap_din), .bitmap_we(bitmap_we), .x(x), .y(y),
        .scale(scale), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ptr, m_win, m_cmd, m_cnt;
    bit          m_act, m_clear, m_pend;
    logic [31:0] m_addr, m_data, m_x, m_y, m_xs, m_ys, m_sc, m_scs;
    logic [31:0] m_last_addr;
    logic [7:0]  m_last_din;
    logic [N-1:0] e_ack;
    bit          e_we, e_busy;

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        bit was_idle;
        if (!reset) begin
            m_ptr = 0; m_win = 0; m_cmd = 0; m_cnt = 0;
            m_act = 0; m_clear = 0; m_pend = 0;
            m_addr = 0; m_data = 0;
            m_x = 0; m_y = 0; m_xs = 0; m_ys = 0; m_sc = 8; m_scs = 8;
            m_last_addr = 0; m_last_din = 0;
        end else begin
            was_idle = !m_act;
            if (frame_start && m_pend) begin
                m_x = m_xs; m_y = m_ys; m_sc = m_scs; m_pend = 0;
            end
            if (m_act) begin
                if (!m_clear) begin
                    if (m_cmd == 1) begin
                        m_xs = {{16{m_data[15]}}, m_data[15:0]};
                        m_ys = {{16{m_data[31]}}, m_data[31:16]};
                        m_pend = 1;
                    end else if (m_cmd == 2) begin
                        m_scs = 32'(m_data[3:0]);
                        m_pend = 1;
                    end
                    m_act = 0;
                end else if (m_cnt == DEPTH - 1) begin
                    m_act = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (was_idle) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!m_act && req_valid[c]) begin
                        m_act   = 1;
                        m_win   = c;
                        m_cmd   = int'(req_cmd[2*c +: 2]);
                        m_addr  = req_addr[32*c +: 32] % DEPTH;
                        m_data  = req_data[32*c +: 32];
                        m_clear = (m_cmd == 3);
                        m_cnt   = 0;
                        m_ptr   = (c + 1) % N;
                    end
                end
            end
        end
        e_busy = m_act;
        e_we   = m_act && (m_clear || m_cmd == 0);
        if (e_we) begin
            m_last_addr = m_clear ? 32'(m_cnt) : m_addr;
            m_last_din  = m_data[7:0];
        end
        e_ack = (m_act && (!m_clear || m_cnt == DEPTH - 1)) ? N'(1 << m_win) : '0;
    endtask

    // One clock: model the edge, let the DUT take it, compare mid-cycle.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("ack",   32'(req_ack),   32'(e_ack));
        check("we",    32'(bitmap_we), 32'(e_we));
        check("addr",  bitmap_address, m_last_addr);
        check("din",   32'(bitmap_din), 32'(m_last_din));
        check("busy",  32'(busy),      32'(e_busy));
        check("x",     x,              m_x);
        check("y",     y,              m_y);
        check("scale", scale,          m_sc);
    endtask

    task automatic set_req(input int i, input logic [1:0] cmd, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid[i]        = 1'b1;
        req_cmd[2*i +: 2]   = cmd;
        req_addr[32*i +: 32] = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic rand_req(input int i);
        int r;
        logic [1:0] cmd;
        r = $urandom_range(0, 15);
        if (r == 0)      cmd = 2'd3;
        else if (r <= 4) cmd = 2'd1;
        else if (r <= 7) cmd = 2'd2;
        else             cmd = 2'd0;
        set_req(i, cmd, $urandom, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int clr_t, sc_t;

        // Reset with every requester asking.
        reset = 1'b0; req_valid = '1; req_cmd = '0; req_addr = '0; req_data = '0;
        frame_start = 1'b0;
        step(); step();
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_we", 32'(bitmap_we), 32'd0);
        check("rst_x", x, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_scale", scale, 32'd8);
        req_valid = '0; reset = 1'b1;
        step();

        // Single PIXEL write.
        set_req(0, 2'd0, 32'h05, 32'h3C);
        step();
        check("pix_we", 32'(bitmap_we), 32'd1);
        check("pix_addr", bitmap_address, 32'd5);
        check("pix_din", 32'(bitmap_din), 32'h3C);
        check("pix_ack", 32'(req_ack), 32'b0001);
        req_valid = '0;
        step();
        check("pix_hold", bitmap_address, 32'd5);

        // Round-robin order with all requesters held.
        reset = 1'b0; step(); reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 32'(i + 1), 32'(8'h10 + i));
        for (int k = 0; k < 10; k++) begin
            step();
            if (k % 2 == 0) check("rr_ack", 32'(req_ack), 32'(1 << ((k / 2) % N)));
            else            check("rr_gap", 32'(req_ack), 32'd0);
        end
        req_valid = '0;
        step();

        // POS commit on frame_start.
        set_req(2, 2'd1, 32'd0, 32'hFFF0_0020);
        step();
        check("pos_ack", 32'(req_ack), 32'b0100);
        req_valid = '0;
        step();
        check("pos_x_pre", x, 32'd0);
        check("pos_y_pre", y, 32'd0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("pos_x", x, 32'd32);
        check("pos_y", y, 32'hFFFF_FFF0);

        // POS issuing in the frame_start cycle lands one frame later.
        set_req(1, 2'd1, 32'd0, 32'h0003_0002);
        step(); req_valid = '0; step();
        set_req(3, 2'd1, 32'd0, 32'h0005_0007);
        step();
        req_valid = '0; frame_start = 1'b1; step(); frame_start = 1'b0;
        check("coinc_x_old", x, 32'd2);
        check("coinc_y_old", y, 32'd3);
        step();
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("coinc_x_new", x, 32'd7);
        check("coinc_y_new", y, 32'd5);

        // Full CLEAR sweep.
        set_req(2, 2'd3, 32'd0, 32'hAA);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check("clr_we", 32'(bitmap_we), 32'd1);
            check("clr_addr", bitmap_address, 32'(k));
            check("clr_din", 32'(bitmap_din), 32'hAA);
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_ack", 32'(req_ack), (k == DEPTH - 1) ? 32'b0100 : 32'd0);
        end
        req_valid = '0;
        step();
        check("clr_done_busy", 32'(busy), 32'd0);
        check("clr_done_addr", bitmap_address, 32'd15);

        // CLEAR aborted by reset at the 8th write.
        set_req(1, 2'd3, 32'd0, 32'h55);
        for (int k = 0; k < 8; k++) begin
            step();
            check("abort_ack", 32'(req_ack), 32'd0);
        end
        reset = 1'b0; req_valid = '0;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(bitmap_we), 32'd0);
        reset = 1'b1;
        step();
        check("abort_idle", 32'(busy), 32'd0);

        // SCALE held off by a CLEAR, then committed at the next frame.
        set_req(0, 2'd3, 32'd0, 32'h11);
        step();
        set_req(1, 2'd2, 32'd0, 32'h0000_0003);
        clr_t = -1; sc_t = -1;
        for (int t = 0; t < 40 && sc_t < 0; t++) begin
            step();
            if (req_ack[0] && clr_t < 0) clr_t = t;
            if (req_ack[1] && sc_t < 0)  sc_t = t;
            if (e_ack[0]) req_valid[0] = 1'b0;
            if (e_ack[1]) req_valid[1] = 1'b0;
        end
        check("hold_clear_ack", 32'(clr_t), 32'd14);
        check("hold_scale_ack", 32'(sc_t), 32'd16);
        req_valid = '0;
        step();
        check("scale_pre", scale, 32'd8);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("scale_commit", scale, 32'd3);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            frame_start = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                if (!reset || e_ack[i])                        req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
